alu_share_arbiter: RTL and testbench

Shares one ALU (alu_control plus ALU datapath) between two requesters, e.g. the main datapath and a secondary address/compare unit. Round-robin arbitration on valid/ready request ports. The granted operation is registered and driven to the ALU for a programmable settle window. The result and zero flag are captured and returned on a single valid/ready response port tagged with the requester id.

---
 rtl/alu_share_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Time-shares one ALU (alu_control + ALU datapath) between two requesters.
//   In IDLE a round-robin arbiter picks one requester. The winner's operation
//   is registered onto the alu_* outputs and held for SETTLE cycles. The ALU
//   result and zero flag are then captured and returned on a response port
//   tagged with the requester id.
//
// Handshake rule, used by every port of this block: a transfer happens on a
// rising clk edge where valid and ready are both high. A producer holds its
// payload stable while valid is high and ready is low. A requester may drop
// valid before it is accepted.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   r0_* / r1_*                   request ports: valid, ready, aluop[2:0],
//                                 func[5:0], a, b
//   alu_aluop, alu_func           registered operation to alu_control
//   alu_a, alu_b                  registered operands to the ALU
//   alu_result, alu_zero          ALU outputs, sampled at the end of ISSUE
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_result, rsp_zero  response payload
//   dbg_state                     FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//   dbg_last_id                   id of the most recently accepted requester
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_aluop,
  input  logic [5:0]       r0_func,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_aluop,
  input  logic [5:0]       r1_func,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [2:0]       alu_aluop,
  output logic [5:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [1:0]       dbg_state,
  output logic             dbg_last_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // The counter counts down from SETTLE-1 to 0. This gives SETTLE cycles in ISSUE.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       aluop_q, aluop_d;
  logic [5:0]       func_q, func_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic grant0, grant1, acc0, acc1;

  // Round robin: a lone requester always wins. Under contention, the
  // requester that was not served last wins. At reset last_id is 1, so r0 wins the first contention.
  // The two grants are mutually exclusive by construction.
  always_comb begin
    grant0 = r0_valid & (~r1_valid | last_id_q);
    grant1 = r1_valid & (~r0_valid | ~last_id_q);
  end

  assign r0_ready = (state_q == S_IDLE) & grant0;
  assign r1_ready = (state_q == S_IDLE) & grant1;
  assign acc0     = r0_valid & r0_ready;
  assign acc1     = r1_valid & r1_ready;

  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    cnt_d        = cnt_q;
    aluop_d      = aluop_q;
    func_d       = func_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (acc0 || acc1) begin
          state_d   = S_ISSUE;
          last_id_d = acc1;
          rsp_id_d  = acc1;
          cnt_d     = CNT_LOAD;
          aluop_d   = acc1 ? r1_aluop : r0_aluop;
          func_d    = acc1 ? r1_func  : r0_func;
          a_d       = acc1 ? r1_a     : r0_a;
          b_d       = acc1 ? r1_b     : r0_b;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // rsp_valid is always high in RESP, so rsp_ready alone completes the
        // handshake. IDLE is entered next cycle, so nothing is accepted in this cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_id_q    <= 1'b1;
      cnt_q        <= 4'd0;
      aluop_q      <= 3'd0;
      func_q       <= 6'd0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      cnt_q        <= cnt_d;
      aluop_q      <= aluop_d;
      func_q       <= func_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_aluop   = aluop_q;
  assign alu_func    = func_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign dbg_state   = state_q;
  assign dbg_last_id = last_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Two instances share a clock and reset. Instance "a" uses SETTLE=1 and
// instance "b" uses SETTLE=3. A small behavioural ALU closes the loop for each
// instance: 001 add, 010 subtract, anything else AND.
// Inputs change 1 time unit after a rising edge. Checks are made 1 time unit
// after that.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- instance a (SETTLE=1) ----------------
  logic         a_r0_valid, a_r0_ready, a_r1_valid, a_r1_ready;
  logic [2:0]   a_r0_aluop, a_r1_aluop, a_alu_aluop;
  logic [5:0]   a_r0_func, a_r1_func, a_alu_func;
  logic [W-1:0] a_r0_a, a_r0_b, a_r1_a, a_r1_b, a_alu_a, a_alu_b, a_alu_result, a_rsp_result;
  logic         a_alu_zero, a_rsp_valid, a_rsp_ready, a_rsp_id, a_rsp_zero, a_last_id;
  logic [1:0]   a_state;

  // ---------------- instance b (SETTLE=3) ----------------
  logic         b_r0_valid, b_r0_ready, b_r1_valid, b_r1_ready;
  logic [2:0]   b_r0_aluop, b_r1_aluop, b_alu_aluop;
  logic [5:0]   b_r0_func, b_r1_func, b_alu_func;
  logic [W-1:0] b_r0_a, b_r0_b, b_r1_a, b_r1_b, b_alu_a, b_alu_b, b_alu_result, b_rsp_result;
  logic         b_alu_zero, b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero, b_last_id;
  logic [1:0]   b_state;

  function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    case (op)
      3'b001:  return x + y;
      3'b010:  return x - y;
      default: return x & y;
    endcase
  endfunction

  assign a_alu_result = alu_model(a_alu_aluop, a_alu_a, a_alu_b);
  assign a_alu_zero   = (a_alu_result == '0);
  assign b_alu_result = alu_model(b_alu_aluop, b_alu_a, b_alu_b);
  assign b_alu_zero   = (b_alu_result == '0);

  alu_share_arbiter #(.WIDTH(W), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(a_r0_valid), .r0_ready(a_r0_ready), .r0_aluop(a_r0_aluop), .r0_func(a_r0_func),
    .r0_a(a_r0_a), .r0_b(a_r0_b),
    .r1_valid(a_r1_valid), .r1_ready(a_r1_ready), .r1_aluop(a_r1_aluop), .r1_func(a_r1_func),
    .r1_a(a_r1_a), .r1_b(a_r1_b),
    .alu_aluop(a_alu_aluop), .alu_func(a_alu_func), .alu_a(a_alu_a), .alu_b(a_alu_b),
    .alu_result(a_alu_result), .alu_zero(a_alu_zero),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
    .rsp_result(a_rsp_result), .rsp_zero(a_rsp_zero),
    .dbg_state(a_state), .dbg_last_id(a_last_id)
  );

  alu_share_arbiter #(.WIDTH(W), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_aluop(b_r0_aluop), .r0_func(b_r0_func),
    .r0_a(b_r0_a), .r0_b(b_r0_b),
    .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_aluop(b_r1_aluop), .r1_func(b_r1_func),
    .r1_a(b_r1_a), .r1_b(b_r1_b),
    .alu_aluop(b_alu_aluop), .alu_func(b_alu_func), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_result(b_alu_result), .alu_zero(b_alu_zero),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero),
    .dbg_state(b_state), .dbg_last_id(b_last_id)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a0(input logic v, input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    a_r0_valid = v; a_r0_aluop = op; a_r0_func = 6'h20; a_r0_a = x; a_r0_b = y;
  endtask

  task automatic drive_a1(input logic v, input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    a_r1_valid = v; a_r1_aluop = op; a_r1_func = 6'h22; a_r1_a = x; a_r1_b = y;
  endtask

  // Checks every output of instance a against its reset value.
  task automatic chk_a_reset(input string tag);
    chk({tag, "_r0_ready"}, 64'(a_r0_ready), 64'd0);
    chk({tag, "_r1_ready"}, 64'(a_r1_ready), 64'd0);
    chk({tag, "_alu_aluop"}, 64'(a_alu_aluop), 64'd0);
    chk({tag, "_alu_func"}, 64'(a_alu_func), 64'd0);
    chk({tag, "_alu_a"}, 64'(a_alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(a_alu_b), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(a_rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(a_rsp_id), 64'd0);
    chk({tag, "_rsp_result"}, 64'(a_rsp_result), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(a_rsp_zero), 64'd0);
    chk({tag, "_state"}, 64'(a_state), 64'd0);
    chk({tag, "_last_id"}, 64'(a_last_id), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive_a0(1'b0, 3'd0, '0, '0);
    drive_a1(1'b0, 3'd0, '0, '0);
    a_rsp_ready = 1'b1;
    b_r0_valid = 1'b0; b_r0_aluop = 3'd0; b_r0_func = 6'd0; b_r0_a = '0; b_r0_b = '0;
    b_r1_valid = 1'b0; b_r1_aluop = 3'd0; b_r1_func = 6'd0; b_r1_a = '0; b_r1_b = '0;
    b_rsp_ready = 1'b1;
    #12 rst_n = 1'b1;
    tick();

    // Reset values
    chk_a_reset("rst_a");
    chk("rst_b_rsp_valid", 64'(b_rsp_valid), 64'd0);
    chk("rst_b_last_id", 64'(b_last_id), 64'd1);

    // Contention from reset: r0 wins first. This is also the single-op timing check.
    drive_a0(1'b1, 3'b001, 32'd5, 32'd7);
    drive_a1(1'b1, 3'b001, 32'd10, 32'd20);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd30);
    #1;
    chk("c0_r0_ready", 64'(a_r0_ready), 64'd1);
    chk("c0_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();                                   // cycle 1: ISSUE
    a_r0_valid = 1'b0;
    #1;
    chk("c1_state", 64'(a_state), 64'd1);
    chk("c1_alu_a", 64'(a_alu_a), 64'd5);
    chk("c1_alu_b", 64'(a_alu_b), 64'd7);
    chk("c1_alu_aluop", 64'(a_alu_aluop), 64'd1);
    chk("c1_alu_func", 64'(a_alu_func), 64'h20);
    chk("c1_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("c1_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();                                   // cycle 2: RESP
    exp_v = exp_q.pop_front();
    chk("c2_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("c2_rsp_id", 64'(a_rsp_id), 64'd0);
    chk("c2_rsp_result", 64'(a_rsp_result), 64'(exp_v));
    chk("c2_rsp_zero", 64'(a_rsp_zero), 64'd0);
    chk("c2_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();                                   // cycle 3: IDLE, r1 granted
    chk("c3_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("c3_alu_a_held", 64'(a_alu_a), 64'd5);
    chk("c3_r1_ready", 64'(a_r1_ready), 64'd1);
    chk("c3_r0_ready", 64'(a_r0_ready), 64'd0);
    tick();                                   // cycle 4: ISSUE for r1
    a_r1_valid = 1'b0;
    #1;
    chk("c4_alu_a", 64'(a_alu_a), 64'd10);
    tick();                                   // cycle 5: RESP for r1
    exp_v = exp_q.pop_front();
    chk("c5_rsp_id", 64'(a_rsp_id), 64'd1);
    chk("c5_rsp_result", 64'(a_rsp_result), 64'(exp_v));
    tick();                                   // cycle 6: IDLE
    chk("c6_last_id", 64'(a_last_id), 64'd1);

    // Second contention: last_id=1, so r0 wins again. Response backpressure follows.
    // r1 stays valid during r0's op and withdraws before IDLE.
    drive_a0(1'b1, 3'b001, 32'h100, 32'h23);
    drive_a1(1'b1, 3'b010, 32'd50, 32'd8);
    a_rsp_ready = 1'b0;
    exp_q.push_back(32'h123);
    #1;
    chk("c6_r0_ready", 64'(a_r0_ready), 64'd1);
    chk("c6_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();                                   // cycle 7: ISSUE
    a_r0_valid = 1'b0;
    #1;
    chk("c7_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();                                   // cycle 8: RESP, rsp_ready=0
    exp_v = exp_q.pop_front();
    chk("c8_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("c8_rsp_result", 64'(a_rsp_result), 64'(exp_v));
    for (int i = 0; i < 3; i++) begin         // cycles 9..11 held
      tick();
      chk("bp_rsp_valid", 64'(a_rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(a_rsp_result), 64'(exp_v));
      chk("bp_rsp_id", 64'(a_rsp_id), 64'd0);
      chk("bp_r0_ready", 64'(a_r0_ready), 64'd0);
      chk("bp_r1_ready", 64'(a_r1_ready), 64'd0);
      chk("bp_state", 64'(a_state), 64'd2);
    end
    a_r1_valid = 1'b0;                        // r1 withdraws before IDLE
    a_rsp_ready = 1'b1;
    tick();                                   // cycle 12: IDLE
    chk("c12_state", 64'(a_state), 64'd0);
    chk("c12_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("c12_r1_ready", 64'(a_r1_ready), 64'd0);
    chk("c12_last_id", 64'(a_last_id), 64'd0);

    // last_id=0 now, so r1 wins this contention.
    drive_a0(1'b1, 3'b001, 32'd1, 32'd1);
    drive_a1(1'b1, 3'b010, 32'd50, 32'd8);
    exp_q.push_back(32'd42);
    #1;
    chk("c12_rr_r1_ready", 64'(a_r1_ready), 64'd1);
    chk("c12_rr_r0_ready", 64'(a_r0_ready), 64'd0);
    tick();
    a_r0_valid = 1'b0;
    a_r1_valid = 1'b0;
    tick();
    exp_v = exp_q.pop_front();
    chk("rr_rsp_id", 64'(a_rsp_id), 64'd1);
    chk("rr_rsp_result", 64'(a_rsp_result), 64'(exp_v));
    tick();

    // Zero flag with SETTLE=3 on instance b. r1 computes 9-9.
    b_r1_valid = 1'b1; b_r1_aluop = 3'b010; b_r1_func = 6'h3f; b_r1_a = 32'd9; b_r1_b = 32'd9;
    exp_q.push_back(32'd0);
    #1;
    chk("z_r1_ready", 64'(b_r1_ready), 64'd1);
    tick();
    b_r1_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("z_issue_rsp_valid", 64'(b_rsp_valid), 64'd0);
      chk("z_issue_alu_func", 64'(b_alu_func), 64'h3f);
      tick();
    end
    exp_v = exp_q.pop_front();
    chk("z_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("z_rsp_result", 64'(b_rsp_result), 64'(exp_v));
    chk("z_rsp_zero", 64'(b_rsp_zero), 64'd1);
    chk("z_rsp_id", 64'(b_rsp_id), 64'd1);
    tick();
    chk("z_done_state", 64'(b_state), 64'd0);

    // Reset in the middle of ISSUE on instance a
    drive_a0(1'b1, 3'b001, 32'd3, 32'd4);
    #1;
    chk("mr_r0_ready", 64'(a_r0_ready), 64'd1);
    tick();
    a_r0_valid = 1'b0;
    #1;
    chk("mr_state_issue", 64'(a_state), 64'd1);
    chk("mr_alu_a", 64'(a_alu_a), 64'd3);
    rst_n = 1'b0;
    #1;
    chk_a_reset("mr");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_rsp0", 64'(a_rsp_valid), 64'd0);
    tick();
    chk("mr_no_rsp1", 64'(a_rsp_valid), 64'd0);

    // After reset, r0 again wins the first contention. The op runs normally.
    drive_a0(1'b1, 3'b001, 32'd100, 32'd23);
    drive_a1(1'b1, 3'b000, 32'hf0, 32'h3c);
    exp_q.push_back(32'd123);
    #1;
    chk("pr_r0_ready", 64'(a_r0_ready), 64'd1);
    chk("pr_r1_ready", 64'(a_r1_ready), 64'd0);
    tick();
    a_r0_valid = 1'b0;
    a_r1_valid = 1'b0;
    tick();
    exp_v = exp_q.pop_front();
    chk("pr_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("pr_rsp_id", 64'(a_rsp_id), 64'd0);
    chk("pr_rsp_result", 64'(a_rsp_result), 64'(exp_v));
    tick();
    chk("pr_idle", 64'(a_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
